// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/funct constants, ALU-op codes, FSM states and decoded-field types for multicycle_control
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_MULT  = 6'h18;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_RTYPE = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MUL_WAIT, S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_MULT, C_LW, C_SW, C_BEQ, C_J
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
    } fields_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction, flag, ready and control-strobe bundle of the multicycle controller
interface multicycle_control_if #(parameter int OP_W = 6);

    logic [OP_W-1:0] Op_i;
    logic [OP_W-1:0] Funct_i;
    logic            zero_i;
    logic            imem_ready_i;
    logic            dmem_ready_i;
    logic [1:0]      alu_op_o;
    logic            reg_dst_o;
    logic            alu_src_o;
    logic            mem_to_reg_o;
    logic            reg_write_o;
    logic            mem_read_o;
    logic            mem_write_o;
    logic            imem_req_o;
    logic            ir_write_o;
    logic            pc_write_o;
    logic            illegal_o;
    logic            mul_busy_o;
    logic [3:0]      state_o;

    modport master (
        output Op_i, Funct_i, zero_i, imem_ready_i, dmem_ready_i,
        input  alu_op_o, reg_dst_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
               mem_write_o, imem_req_o, ir_write_o, pc_write_o, illegal_o, mul_busy_o, state_o
    );

    modport slave (
        input  Op_i, Funct_i, zero_i, imem_ready_i, dmem_ready_i,
        output alu_op_o, reg_dst_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_read_o,
               mem_write_o, imem_req_o, ir_write_o, pc_write_o, illegal_o, mul_busy_o, state_o
    );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct to instruction class and datapath-select decode
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output fields_t         fields
);

    // unknown opcodes decode to all-zero fields, which doubles as the illegal marker
    always_comb begin
        fields = '0;
        case (op)
            OP_W'(OP_RTYPE): fields = '{funct == OP_W'(FN_MULT) ? C_MULT : C_ALU, ALU_RTYPE, 1'b1, 1'b0, 1'b0};
            OP_W'(OP_ADDI):  fields = '{C_ALU, ALU_ADD, 1'b0, 1'b1, 1'b0};
            OP_W'(OP_ORI):   fields = '{C_ALU, ALU_OR,  1'b0, 1'b1, 1'b0};
            OP_W'(OP_LW):    fields = '{C_LW,  ALU_ADD, 1'b0, 1'b1, 1'b1};
            OP_W'(OP_SW):    fields = '{C_SW,  ALU_ADD, 1'b0, 1'b1, 1'b0};
            OP_W'(OP_BEQ):   fields = '{C_BEQ, ALU_SUB, 1'b0, 1'b0, 1'b0};
            OP_W'(OP_J):     fields = '{C_J,   ALU_ADD, 1'b0, 1'b0, 1'b0};
            default:         fields = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM with fetch/memory handshakes and a fixed-latency multiply wait
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int OP_W       = 6
) (
    input logic                 clk_i,
    input logic                 rst_i,
    multicycle_control_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    fields_t    dec;
    fields_t    lat;
    logic [3:0] cnt;
    logic       illegal;
    logic       fetch;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op     (bus.Op_i),
        .funct  (bus.Funct_i),
        .fields (dec)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    // decode fields held from one DECODE to the next, multiply dwell counter, registered illegal pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat     <= '0;
            cnt     <= '0;
            illegal <= 1'b0;
        end else begin
            if (state == S_DECODE)
                lat <= dec;
            cnt     <= state == S_DECODE && state_nxt == S_MUL_WAIT ? 4'(MUL_CYCLES - 1)
                     : state == S_MUL_WAIT && cnt != '0 ? cnt - 4'd1 : cnt;
            illegal <= state == S_DECODE && dec.cls == C_NONE;
        end
    end

    // next-state logic; WB, BRANCH and JUMP always return to FETCH
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = bus.imem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:   state_nxt = dec.cls == C_MULT ? S_MUL_WAIT
                                  : dec.cls == C_BEQ  ? S_BRANCH
                                  : dec.cls == C_J    ? S_JUMP
                                  : dec.cls == C_NONE ? S_FETCH : S_EXEC;
            S_EXEC:     state_nxt = lat.cls == C_LW ? S_MEM_RD : lat.cls == C_SW ? S_MEM_WR : S_WB;
            S_MUL_WAIT: state_nxt = cnt == '0 ? S_WB : S_MUL_WAIT;
            S_MEM_RD:   state_nxt = bus.dmem_ready_i ? S_WB : S_MEM_RD;
            S_MEM_WR:   state_nxt = bus.dmem_ready_i ? S_FETCH : S_MEM_WR;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // reset forces FETCH asynchronously, so only the FETCH strobes need masking while rst_i is low
    assign fetch            = rst_i && state == S_FETCH;
    assign bus.imem_req_o   = fetch;
    assign bus.ir_write_o   = fetch && bus.imem_ready_i;
    assign bus.pc_write_o   = fetch && bus.imem_ready_i || state == S_BRANCH && bus.zero_i || state == S_JUMP;
    assign bus.reg_write_o  = state == S_WB;
    assign bus.mem_read_o   = state == S_MEM_RD;
    assign bus.mem_write_o  = state == S_MEM_WR;
    assign bus.mul_busy_o   = state == S_MUL_WAIT;
    assign bus.illegal_o    = illegal;
    assign bus.alu_op_o     = state == S_BRANCH ? ALU_SUB : lat.alu_op;
    assign bus.reg_dst_o    = lat.reg_dst;
    assign bus.alu_src_o    = lat.alu_src;
    assign bus.mem_to_reg_o = lat.mem_to_reg;
    assign bus.state_o      = state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning MUL_WAIT dwell in cycles (legal 1..15).
REQ-002 SHALL have parameter OP_W, default 6, meaning opcode/funct width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Op_i  in  OP_W  instruction opcode from IR, sampled in DECODE.
REQ-006 SHALL have port Funct_i  in  OP_W  R-type funct from IR, sampled in DECODE.
REQ-007 SHALL have port zero_i  in  1  ALU zero flag, sampled in BRANCH.
REQ-008 SHALL have port imem_ready_i  in  1  instruction-memory ready.
REQ-009 SHALL have port dmem_ready_i  in  1  data-memory ready.
REQ-010 SHALL have port alu_op_o  out  2  11 R-type, 00 add, 01 sub, 10 or.
REQ-011 SHALL have ports reg_dst_o, alu_src_o, mem_to_reg_o  out  1 each  datapath selects.
REQ-012 SHALL have ports reg_write_o, mem_read_o, mem_write_o  out  1 each  strobes.
REQ-013 SHALL have ports imem_req_o, ir_write_o, pc_write_o  out  1 each  fetch/PC control.
REQ-014 SHALL have ports illegal_o (1-cycle pulse), mul_busy_o  out  1 each; state_o  out  4  current state.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXEC, MUL_WAIT, MEM_RD, MEM_WR, WB, BRANCH, JUMP.
REQ-016 FETCH: imem_req_o=1; when imem_ready_i=1, ir_write_o=1 and pc_write_o=1 for that cycle, then DECODE; otherwise stay.
REQ-017 DECODE: latch opcode-class, alu_op, reg_dst, alu_src, mem_to_reg into registers held until the next DECODE.
REQ-018 DECODE transitions: 0x00 with funct 0x18 (mult) to MUL_WAIT; other 0x00, 0x08, 0x0D, 0x23, 0x2B to EXEC; 0x04 to BRANCH; 0x02 to JUMP.
REQ-019 Any other opcode SHALL go to FETCH with illegal_o=1 for exactly one cycle; latched fields SHALL be 0.
REQ-020 EXEC: next state MEM_RD for 0x23, MEM_WR for 0x2B, WB otherwise.
REQ-021 MUL_WAIT: load counter with MUL_CYCLES-1 on entry; decrement each cycle; go to WB on the cycle the counter equals 0; mul_busy_o=1 throughout.
REQ-022 MEM_RD: mem_read_o=1; go to WB on dmem_ready_i=1, otherwise stay.
REQ-023 MEM_WR: mem_write_o=1; go to FETCH on dmem_ready_i=1, otherwise stay.
REQ-024 WB: reg_write_o=1 for exactly one cycle, then FETCH.
REQ-025 BRANCH: alu_op_o=01; pc_write_o=zero_i; then FETCH.
REQ-026 JUMP: pc_write_o=1, then FETCH.
REQ-027 Strobes (reg_write_o, mem_read_o, mem_write_o, imem_req_o, ir_write_o, pc_write_o) SHALL be Moore outputs of the current state, except the ready/zero qualification in REQ-016, REQ-025.
REQ-028 Latency with ready tied high: R-type/addi/ori 4, lw 5, sw 4, beq 3, j 3, mult 3+MUL_CYCLES cycles, FETCH to FETCH.
REQ-029 A ready held low SHALL stall indefinitely without changing any latched field.

Reset
REQ-030 rst_i=0 SHALL immediately force state FETCH, counter 0, latched fields 0 and every output 0.
REQ-031 The first cycle after release SHALL be FETCH with imem_req_o=1.
REQ-032 Reset asserted in any state, including MUL_WAIT and MEM_WR, SHALL abort the operation with no strobe issued.

Structure
REQ-033 Package ctrl_pkg SHALL hold opcode/funct constants, ALU-op codes and the state enumeration.
REQ-034 Combinational opcode-to-field decode SHALL be sub-module ctrl_decode, instantiated once.
REQ-035 The FSM and MUL counter SHALL be in multicycle_control.

Verification
REQ-036 lw (0x23), readys=1 -> states FETCH,DECODE,EXEC,MEM_RD,WB; mem_to_reg_o=1; reg_write_o high in cycle 5 only.
REQ-037 beq (0x04), zero_i=1 then repeated with zero_i=0 -> pc_write_o=1 in BRANCH first run, 0 second run; 3 cycles each.
REQ-038 mult (Op 0x00, Funct 0x18), MUL_CYCLES=4 -> mul_busy_o high 4 cycles, WB at cycle 7; rerun with MUL_CYCLES=1 -> WB at cycle 4.
REQ-039 sw with dmem_ready_i low 3 cycles -> mem_write_o high 4 cycles, then FETCH; reg_write_o never high.
REQ-040 Op 0x3F -> illegal_o high 1 cycle, return to FETCH after 2 cycles, all strobes 0.
REQ-041 rst_i low mid-MUL_WAIT (counter=2) -> outputs 0 without waiting for a clock edge; after release state_o=FETCH, no WB issued.
